// File: rtl/clock_period_meter.sv
// Measures high time, low time and period of a slow asynchronous square wave in clk cycles,
// with a divisor-match flag and a sticky loss-of-signal flag.
module clock_period_meter #(
    parameter int          CNT_WIDTH = 32,
    parameter int unsigned TIMEOUT   = 50_000_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sig_in,
    input  logic                 clear,
    input  logic [CNT_WIDTH-1:0] expected_div,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic [CNT_WIDTH-1:0] low_time,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 meas_valid,
    output logic                 period_valid,
    output logic                 match,
    output logic                 timeout
);

    localparam logic [1:0] ST_ACQUIRE = 2'd0;
    localparam logic [1:0] ST_HIGH    = 2'd1;
    localparam logic [1:0] ST_LOW     = 2'd2;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    logic                 sync_1;
    logic                 s;
    logic                 s_d;
    logic                 rise;
    logic                 fall;
    logic                 edge_det;
    logic                 hit_timeout;
    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [CNT_WIDTH:0]   period_sum;
    logic [CNT_WIDTH-1:0] period_sat;

    // Two flops resolve metastability on sig_in; the third gives the previous sample for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            s      <= 1'b0;
            s_d    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make the three flops shift one stage per clock regardless of statement order.
            sync_1 <= sig_in;
            s      <= sync_1;
            s_d    <= s;
        end
    end

    assign rise        = s & ~s_d;
    assign fall        = ~s & s_d;
    assign edge_det    = rise | fall;
    assign hit_timeout = !edge_det && (cnt == TIMEOUT_CNT);
    assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_WIDTH'(1);

    // One extra bit catches overflow of high + low so the period saturates instead of wrapping.
    assign period_sum = {1'b0, high_time} + {1'b0, cnt};
    assign period_sat = period_sum[CNT_WIDTH] ? CNT_MAX : period_sum[CNT_WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_ACQUIRE;
            cnt          <= '0;
            high_time    <= '0;
            low_time     <= '0;
            period       <= '0;
            meas_valid   <= 1'b0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (clear) begin
                state        <= ST_ACQUIRE;
                cnt          <= '0;
                period_valid <= 1'b0;
                timeout      <= 1'b0;
            end else if (hit_timeout) begin
                state        <= ST_ACQUIRE;
                cnt          <= '0;
                period_valid <= 1'b0;
                timeout      <= 1'b1;
            end else begin
                cnt <= edge_det ? CNT_WIDTH'(1) : cnt_inc;
                case (state)
                    ST_ACQUIRE: begin
                        if (rise) state <= ST_HIGH;
                    end
                    ST_HIGH: begin
                        if (fall) begin
                            high_time <= cnt;
                            state     <= ST_LOW;
                        end
                    end
                    ST_LOW: begin
                        if (rise) begin
                            low_time     <= cnt;
                            period       <= period_sat;
                            meas_valid   <= 1'b1;
                            period_valid <= 1'b1;
                            timeout      <= 1'b0;
                            state        <= ST_HIGH;
                        end
                    end
                    default: state <= ST_ACQUIRE;
                endcase
            end
        end
    end

    // Doubling in CNT_WIDTH+1 bits keeps a large expected_div from wrapping onto a small period.
    assign match = period_valid && ({1'b0, period} == {expected_div, 1'b0});

endmodule

// File: tb/tb_clock_period_meter.sv
// Randomized scoreboard bench for clock_period_meter: the stimulus pushes expected (high, low) pairs,
// a negedge monitor pops and compares them whenever meas_valid pulses.
module tb_clock_period_meter;

    localparam int W  = 32;
    localparam int TO = 100;
    localparam int NW = 4;
    localparam int NT = 14;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sig_in = 1'b0;
    logic          clear = 1'b0;
    logic [W-1:0]  expected_div = 32'd5;
    logic [W-1:0]  high_time, low_time, period;
    logic          meas_valid, period_valid, match, timeout;

    logic          sig_n = 1'b0;
    logic          clear_n = 1'b0;
    logic [NW-1:0] expected_div_n = 4'd15;
    logic [NW-1:0] high_time_n, low_time_n, period_n;
    logic          meas_valid_n, period_valid_n, match_n, timeout_n;

    clock_period_meter #(.CNT_WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .clear(clear),
        .expected_div(expected_div), .high_time(high_time), .low_time(low_time),
        .period(period), .meas_valid(meas_valid), .period_valid(period_valid),
        .match(match), .timeout(timeout)
    );

    clock_period_meter #(.CNT_WIDTH(NW), .TIMEOUT(NT)) dut_narrow (
        .clk(clk), .reset_n(reset_n), .sig_in(sig_n), .clear(clear_n),
        .expected_div(expected_div_n), .high_time(high_time_n), .low_time(low_time_n),
        .period(period_n), .meas_valid(meas_valid_n), .period_valid(period_valid_n),
        .match(match_n), .timeout(timeout_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int h;
        int l;
        bit chain;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   last_pushed = 1'b0;
    int   last_l = 0;
    int   last_p = 0;
    int   last_pub_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: every meas_valid pulse must correspond to one completed wave cycle in the scoreboard.
    always @(negedge clk) begin
        if (reset_n && meas_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_meas_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("high_time", high_time, mon_e.h);
                check("low_time", low_time, mon_e.l);
                check("period", period, mon_e.h + mon_e.l);
                check("match", match, 64'(mon_e.h + mon_e.l) == 2 * 64'(expected_div));
                check("period_valid_at_publish", period_valid, 1);
                check("timeout_at_publish", timeout, 0);
                if (mon_e.chain) check("publish_spacing", cyc - last_pub_cyc, mon_e.h + mon_e.l);
                last_l = mon_e.l;
                last_p = mon_e.h + mon_e.l;
            end
            last_pub_cyc = cyc;
        end
    end

    // One full input cycle: high for h clk, low for l clk. Its measurement appears at the next rise.
    task automatic drive_seg(input int h, input int l);
        exp_t e;
        sig_in = 1'b1;
        repeat (h) @(posedge clk);
        #1 sig_in = 1'b0;
        repeat (l) @(posedge clk);
        #1;
        e.h = h;
        e.l = l;
        e.chain = last_pushed;
        sb.push_back(e);
        last_pushed = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_high_time"}, high_time, 0);
        check({tag, "_low_time"}, low_time, 0);
        check({tag, "_period"}, period, 0);
        check({tag, "_meas_valid"}, meas_valid, 0);
        check({tag, "_period_valid"}, period_valid, 0);
        check({tag, "_match"}, match, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int t0;
        int h;
        int l;
        int e;

        #22;
        check_reset_state("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Divider-style wave, divisor 5.
        expected_div = 32'd5;
        repeat (6) drive_seg(5, 5);

        // Divisor 1 wave, first expecting a match, then not.
        expected_div = 32'd1;
        repeat (4) drive_seg(1, 1);
        expected_div = 32'd2;
        repeat (4) drive_seg(1, 1);

        // Asymmetric duty, then a duty change.
        expected_div = 32'd5;
        repeat (3) drive_seg(3, 7);
        repeat (3) drive_seg(7, 3);

        // Randomized waves, about half chosen to match the expected divisor.
        for (int b = 0; b < 4; b++) begin
            e = $urandom_range(1, 12);
            expected_div = W'(e);
            for (int i = 0; i < 10; i++) begin
                h = $urandom_range(1, 12);
                l = $urandom_range(1, 12);
                if ($urandom_range(0, 1) == 1 && 2 * e - h >= 1) l = 2 * e - h;
                drive_seg(h, l);
            end
        end

        // Clear in the middle of a low phase: the partial cycle must never publish.
        sig_in = 1'b1;
        repeat (6) @(posedge clk);
        #1 sig_in = 1'b0;
        repeat (10) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        check("clear_period_valid", period_valid, 0);
        check("clear_timeout", timeout, 0);
        check("clear_match", match, 0);
        check("clear_high_time", high_time, 6);
        check("clear_low_time_hold", low_time, last_l);
        check("clear_period_hold", period, last_p);
        repeat (8) @(posedge clk);
        #1;
        last_pushed = 1'b0;
        expected_div = 32'd4;
        repeat (3) drive_seg(4, 4);

        // Reset pulse in the middle of a high phase.
        sig_in = 1'b1;
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b0;
        #2 check_reset_state("midreset");
        repeat (2) @(posedge clk);
        #1 sig_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        last_pushed = 1'b0;
        expected_div = 32'd6;
        repeat (3) drive_seg(2, 10);

        // Signal loss: lock, then hold the input high.
        expected_div = 32'd5;
        repeat (2) drive_seg(5, 5);
        sig_in = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!meas_valid && k < 20);
        check("timeout_lock_publish_seen", meas_valid, 1);
        t0 = cyc;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!timeout && k < 300);
        check("timeout_latency", cyc - t0, TO);
        check("timeout_period_valid", period_valid, 0);
        check("timeout_period_hold", period, 10);
        check("timeout_match", match, 0);
        repeat (150) @(negedge clk);
        check("timeout_sticky", timeout, 1);
        @(posedge clk);
        #1 sig_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        last_pushed = 1'b0;
        repeat (3) drive_seg(5, 5);

        // Final rise so the last segment publishes.
        sig_in = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        // Narrow counter: 10 + 10 saturates at 15.
        for (int i = 0; i < 2; i++) begin
            sig_n = 1'b1;
            repeat (10) @(posedge clk);
            #1 sig_n = 1'b0;
            repeat (10) @(posedge clk);
            #1;
        end
        sig_n = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!meas_valid_n && k < 20);
        check("narrow_publish_seen", meas_valid_n, 1);
        check("narrow_high_time", high_time_n, 10);
        check("narrow_low_time", low_time_n, 10);
        check("narrow_period_saturated", period_n, 15);
        check("narrow_match", match_n, 0);
        check("narrow_period_valid", period_valid_n, 1);
        check("narrow_timeout", timeout_n, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
